// File: rtl/serial_signed_compare_pkg.sv
// Shared definitions for the serial signed comparator: FSM encoding and
// digit-counter sizing.
package serial_signed_compare_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SCAN = 2'b01,
      DONE = 2'b10
   } state_t;

   // Counter must hold NDIG-1; a single-digit configuration still gets one bit.
   function automatic int cnt_width(input int ndig);
      return (ndig > 1) ? $clog2(ndig) : 1;
   endfunction

endpackage

// File: rtl/serial_signed_compare_digit_compare.sv
// Combinational unsigned compare of one DIGIT-wide slice; the top slice has its
// MSB inverted so two's-complement order maps onto unsigned order.
module digit_compare #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             is_top,
   output logic             d_lt,
   output logic             d_gt
);

   logic [DIGIT-1:0] flip;
   logic [DIGIT-1:0] a_c;
   logic [DIGIT-1:0] b_c;

   always_comb begin
      flip            = '0;
      flip[DIGIT-1]   = is_top;
      a_c             = a ^ flip;
      b_c             = b ^ flip;
      d_lt            = (a_c < b_c);
      d_gt            = (a_c > b_c);
   end

endmodule

// File: rtl/serial_signed_compare.sv
// Multi-cycle MSB-first signed comparator with early termination at the first
// differing digit; valid/ready handshake on both input and output sides.
module serial_signed_compare
   import serial_signed_compare_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] InA,
   input  logic [WIDTH-1:0] InB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             lt,
   output logic             gt,
   output logic             eq
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = cnt_width(NDIG);

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [CW-1:0]    cnt;
   logic [DIGIT-1:0] a_dig;
   logic [DIGIT-1:0] b_dig;
   logic             is_top;
   logic             d_lt;
   logic             d_gt;

   // Constant-index mux keeps every slice in range for all DIGIT choices.
   always_comb begin
      a_dig  = '0;
      b_dig  = '0;
      for (int unsigned i = 0; i < NDIG; i++) begin
         if (cnt == CW'(i)) begin
            a_dig = a_reg[i*DIGIT +: DIGIT];
            b_dig = b_reg[i*DIGIT +: DIGIT];
         end
      end
      is_top = (cnt == CW'(NDIG - 1));
   end

   digit_compare #(
      .DIGIT (DIGIT)
   ) u_digit_compare (
      .a      (a_dig),
      .b      (b_dig),
      .is_top (is_top),
      .d_lt   (d_lt),
      .d_gt   (d_gt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         lt        <= 1'b0;
         gt        <= 1'b0;
         eq        <= 1'b0;
         cnt       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg    <= InA;
                  b_reg    <= InB;
                  cnt      <= CW'(NDIG - 1);
                  in_ready <= 1'b0;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               if (d_lt || d_gt) begin
                  lt        <= d_lt;
                  gt        <= d_gt;
                  eq        <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (cnt == '0) begin
                  lt        <= 1'b0;
                  gt        <= 1'b0;
                  eq        <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  lt        <= 1'b0;
                  gt        <= 1'b0;
                  eq        <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_signed_compare.sv
// Scoreboard bench: four comparators (DIGIT 1,2,4,16) driven independently and
// checked against a plain signed-arithmetic reference with expected latency.
module tb_serial_signed_compare;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid  [4];
   logic        in_ready  [4];
   logic        out_valid [4];
   logic        out_ready [4];
   logic        lt        [4];
   logic        gt        [4];
   logic        eq        [4];
   logic [15:0] in_a      [4];
   logic [15:0] in_b      [4];

   typedef struct {
      logic lt;
      logic gt;
      logic eq;
      int   lat;
      int   acc;
   } exp_t;

   exp_t exp_q [4][$];
   bit   seen  [4];
   exp_t head;
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;
   bit   rdy_rand = 1'b0;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
      serial_signed_compare #(
         .WIDTH (16),
         .DIGIT (D)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .InA       (in_a[g]),
         .InB       (in_b[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .lt        (lt[g]),
         .gt        (gt[g]),
         .eq        (eq[g])
      );
   end

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int digit_of(input int d);
      return (d == 0) ? 1 : (d == 1) ? 2 : (d == 2) ? 4 : 16;
   endfunction

   // Reference: signed relation from arithmetic; latency from the highest differing bit.
   function automatic exp_t model(input int d, input logic [15:0] a, input logic [15:0] b);
      exp_t        e;
      logic [15:0] x;
      int          p;
      int          dg;
      dg   = digit_of(d);
      x    = a ^ b;
      p    = -1;
      e.lt = ($signed(a) < $signed(b));
      e.gt = ($signed(a) > $signed(b));
      e.eq = (a == b);
      for (int j = 0; j < 16; j++) if (x[j]) p = j;
      e.lat = (p < 0) ? (16 / dg) : ((15 - p) / dg + 1);
      e.acc = 0;
      return e;
   endfunction

   task automatic check(input string name, input int d, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s dut%0d (DIGIT=%0d) t=%0t: actual=%0d required=%0d",
                  name, d, digit_of(d), $time, act, req);
      end
   endtask

   task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b, input bit push);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!in_ready[d] && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready[d]) begin
         check("accept_timeout", d, 0, 1);
         return;
      end
      in_a[d]     = a;
      in_b[d]     = b;
      in_valid[d] = 1'b1;
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
      in_a[d]     = 16'($urandom);
      in_b[d]     = 16'($urandom);
      if (push) begin
         e     = model(d, a, b);
         e.acc = cyc;
         exp_q[d].push_back(e);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
             && n < 2000) begin
         @(posedge clk);
         n++;
      end
      for (int d = 0; d < 4; d++)
         if (exp_q[d].size() != 0) check("drain_timeout", d, exp_q[d].size(), 0);
   endtask

   task automatic rand_ops(input int d);
      logic [15:0] a;
      logic [15:0] b;
      repeat (60) begin
         a = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       b = 16'($urandom);
            1:       b = a ^ (16'd1 << $urandom_range(0, 15));
            2:       b = a;
            default: b = {~a[15], a[14:0]};
         endcase
         issue(d, a, b, 1'b1);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (rdy_rand)
         for (int i = 0; i < 4; i++) out_ready[i] = ($urandom_range(0, 3) != 0);
   end

   // Monitor: compares every presented result against the queue head.
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            if (out_valid[i]) begin
               check("in_ready_busy", i, int'(in_ready[i]), 0);
               if (exp_q[i].size() == 0) begin
                  check("unexpected_result", i, 1, 0);
               end else begin
                  head = exp_q[i][0];
                  if (!seen[i]) begin
                     check("latency", i, cyc - head.acc, head.lat);
                     seen[i] = 1'b1;
                  end
                  check("lt", i, int'(lt[i]), int'(head.lt));
                  check("gt", i, int'(gt[i]), int'(head.gt));
                  check("eq", i, int'(eq[i]), int'(head.eq));
                  if (out_ready[i]) begin
                     void'(exp_q[i].pop_front());
                     seen[i] = 1'b0;
                  end
               end
            end else begin
               check("idle_outputs", i, int'({lt[i], gt[i], eq[i]}), 0);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b1;
         in_a[i]      = '0;
         in_b[i]      = '0;
         seen[i]      = 1'b0;
      end
      #12;
      for (int i = 0; i < 4; i++) begin
         check("reset_in_ready", i, int'(in_ready[i]), 1);
         check("reset_out_valid", i, int'(out_valid[i]), 0);
         check("reset_results", i, int'({lt[i], gt[i], eq[i]}), 0);
      end
      @(negedge clk);
      rst = 1'b0;

      // Reset aborting an op mid-scan
      issue(0, 16'h0001, 16'h0002, 1'b0);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_out_valid", 0, int'(out_valid[0]), 0);
      check("abort_in_ready", 0, int'(in_ready[0]), 1);
      check("abort_results", 0, int'({lt[0], gt[0], eq[0]}), 0);
      #1 rst = 1'b0;
      seen[0] = 1'b0;
      repeat (20) @(posedge clk);

      // Directed patterns and boundaries
      issue(0, 16'h8000, 16'h7FFF, 1'b1);
      issue(0, 16'h7FFF, 16'h8000, 1'b1);
      issue(0, 16'hFFFF, 16'h0000, 1'b1);
      issue(0, 16'h8000, 16'h8000, 1'b1);
      issue(0, 16'h0004, 16'h0005, 1'b1);
      issue(2, 16'h0004, 16'h0005, 1'b1);
      issue(2, 16'hFFFF, 16'hFFFF, 1'b1);
      issue(1, 16'h8000, 16'h7FFF, 1'b1);
      issue(3, 16'hFFFF, 16'h0000, 1'b1);
      issue(3, 16'h8000, 16'h8000, 1'b1);
      drain();

      // Backpressure with ignored in_valid pulses
      @(posedge clk);
      #1 out_ready[0] = 1'b0;
      issue(0, 16'hFFFF, 16'h0001, 1'b1);
      repeat (10) begin
         @(posedge clk);
         #1;
         in_valid[0] = 1'b1;
         in_a[0]     = 16'h0001;
         in_b[0]     = 16'hFFFF;
         @(posedge clk);
         #1 in_valid[0] = 1'b0;
      end
      out_ready[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("release_in_ready", 0, int'(in_ready[0]), 1);
      check("release_out_valid", 0, int'(out_valid[0]), 0);
      repeat (5) @(posedge clk);

      // Random back-to-back traffic on all configurations
      rdy_rand = 1'b1;
      for (int d = 0; d < 4; d++) begin
         automatic int dd = d;
         fork
            rand_ops(dd);
         join_none
      end
      wait fork;
      rdy_rand = 1'b0;
      @(posedge clk);
      #2;
      for (int i = 0; i < 4; i++) out_ready[i] = 1'b1;
      drain();
      repeat (5) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
